fft32_sdf_sequencer: RTL and testbench

- Central sequencer for the 32-point radix-2 single-path delay-feedback (SDF) FFT pipeline.
- The pipeline has five butterfly stages with delay-line depths 16, 8, 4, 2 and 1.
- The sequencer accepts the input sample stream and generates a common datapath advance enable.
- For every stage it drives a 2-bit mode (fill / butterfly / twiddle / idle) and a twiddle exponent for that stage's twiddle ROM.
- It flushes the pipeline after the last frame and tags output samples with valid, bit-reversed index and end-of-frame.

---
 rtl/fft32_sdf_sequencer.sv | 153 +++++++++++++++
 tb/tb_fft32_sdf_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fft32_sdf_sequencer.sv
// Central sequencer for a 32-point radix-2 SDF FFT: datapath advance enable, per-stage
// mode/twiddle decode, end-of-stream flush and output tagging (bit-reversed bin, end-of-frame).
module fft32_sdf_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        advance,
    output logic [9:0]  stage_mode,
    output logic [19:0] tw_idx,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a sample transfers in any cycle with in_valid && in_ready. in_valid low in RUN
    // away from a frame boundary is a stall (nothing moves); in FLUSH in_ready is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FILL = 2'd0;
    localparam logic [1:0] MODE_BFLY = 2'd1;
    localparam logic [1:0] MODE_TWID = 2'd2;
    localparam logic [1:0] MODE_IDLE = 2'd3;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_g, w_g_nxt;
    logic [5:0] r_pc, w_pc_nxt;
    logic [4:0] r_fc, w_fc_nxt;
    logic       w_adv;
    logic       w_dec_en;
    logic [4:0] w_g_plus1;

    // Returns {twiddle exponent, mode} for stage k; delay D = 16>>k, input offset = 32 - 2D.
    function automatic logic [5:0] decode_stage(input logic [4:0] g, input logic [5:0] pc,
                                                input int k);
        logic [5:0] d;
        logic [5:0] off;
        logic [4:0] c;
        logic [4:0] p;
        logic [1:0] mode;
        logic [3:0] e;
        d    = 6'(16 >> k);
        off  = 6'(32 - 2 * (16 >> k));
        c    = g - off[4:0];
        p    = c & 5'(2 * (16 >> k) - 1);
        e    = 4'd0;
        mode = MODE_BFLY;
        if (pc < off) begin
            mode = MODE_IDLE;
        end else if (pc < off + d) begin
            mode = MODE_FILL;
        end else if ({1'b0, p} < d) begin
            mode = MODE_TWID;
            e    = 4'(p << k);
        end
        return {e, mode};
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = v[4 - i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_g     <= 5'd0;
            r_pc    <= 6'd0;
            r_fc    <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_pc    <= w_pc_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_pc_nxt    = r_pc;
        w_fc_nxt    = r_fc;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    w_adv = 1'b1;
                end else if (r_g == 5'd0 && r_pc >= 6'd32) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_adv = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset must silence advance at once even while in_valid is high.
        if (rst) begin
            w_adv = 1'b0;
        end
        if (w_adv) begin
            w_g_nxt  = r_g + 5'd1;
            w_pc_nxt = (r_pc == 6'd63) ? r_pc : r_pc + 6'd1;
        end
        if (r_state == S_FLUSH) begin
            if (r_fc == 5'd30) begin
                w_state_nxt = S_IDLE;
                w_g_nxt     = 5'd0;
                w_pc_nxt    = 6'd0;
                w_fc_nxt    = 5'd0;
            end else begin
                w_fc_nxt = r_fc + 5'd1;
            end
        end
    end

    assign in_ready    = (r_state != S_FLUSH);
    assign advance     = w_adv;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    assign w_g_plus1 = r_g + 5'd1;
    assign out_valid = w_adv && (r_pc >= 6'd31);
    assign out_index = out_valid ? bitrev5(w_g_plus1) : 5'd0;
    assign out_last  = out_valid && (w_g_plus1 == 5'd31);

    // In IDLE the decode only describes a sample actually entering this cycle.
    assign w_dec_en = (r_state != S_IDLE) || w_adv;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        logic [5:0] w_dec;
        assign w_dec                 = decode_stage(r_g, r_pc, k);
        assign stage_mode[2*k +: 2]  = w_dec_en ? w_dec[1:0] : MODE_IDLE;
        assign tw_idx[4*k +: 4]      = w_dec_en ? w_dec[5:2] : 4'd0;
    end

endmodule

// File: tb/tb_fft32_sdf_sequencer.sv
// Directed bench for fft32_sdf_sequencer: single frame, back-to-back frames, stall,
// in_valid held through flush, and reset during flush.
module tb_fft32_sdf_sequencer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        advance;
    logic [9:0]  stage_mode;
    logic [19:0] tw_idx;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    fft32_sdf_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .advance    (advance),
        .stage_mode (stage_mode),
        .tw_idx     (tw_idx),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] brev(input int v);
        logic [4:0] x;
        logic [4:0] r;
        x = 5'(v);
        for (int i = 0; i < 5; i++) r[i] = x[4 - i];
        return r;
    endfunction

    // Expected {tw_idx, stage_mode} for the sample with advance number a since leaving IDLE.
    function automatic logic [29:0] exp_dec(input int a);
        logic [9:0]  m;
        logic [19:0] t;
        int g, pc, d, off, p;
        m  = '0;
        t  = '0;
        g  = a % 32;
        pc = (a > 63) ? 63 : a;
        for (int k = 0; k < 5; k++) begin
            d   = 16 >> k;
            off = (k == 0) ? 0 : (k == 1) ? 16 : (k == 2) ? 24 : (k == 3) ? 28 : 30;
            if (pc < off) begin
                m[2*k +: 2] = 2'd3;
            end else if (pc < off + d) begin
                m[2*k +: 2] = 2'd0;
            end else begin
                p = ((g - off + 32) % 32) % (2 * d);
                if (p < d) begin
                    m[2*k +: 2] = 2'd2;
                    t[4*k +: 4] = 4'(p * (16 / d));
                end else begin
                    m[2*k +: 2] = 2'd1;
                end
            end
        end
        return {t, m};
    endfunction

    task automatic drive(input logic v);
        @(negedge clk);
        in_valid = v;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_advance"}, advance, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_index"}, out_index, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stage_mode"}, stage_mode, 10'h3FF);
        chk({tag, "_tw_idx"}, tw_idx, 0);
        chk({tag, "_state"}, dbg_state, 2'd0);
    endtask

    task automatic check_adv(input int a);
        logic [29:0] e;
        int g;
        e = exp_dec(a);
        g = a % 32;
        chk($sformatf("advance@%0d", a), advance, 1);
        chk($sformatf("mode@%0d", a), stage_mode, e[9:0]);
        chk($sformatf("tw@%0d", a), tw_idx, e[29:10]);
        chk($sformatf("tw4@%0d", a), tw_idx[19:16], 0);
        chk($sformatf("oval@%0d", a), out_valid, (a >= 31) ? 1 : 0);
        chk($sformatf("oidx@%0d", a), out_index, (a >= 31) ? brev((g + 1) % 32) : 5'd0);
        chk($sformatf("olast@%0d", a), out_last, (a >= 31 && (g + 1) % 32 == 31) ? 1 : 0);
        if (a == 15) chk("s0_fill_15", stage_mode[1:0], 2'd0);
        if (a == 16) chk("s0_bfly_16", stage_mode[1:0], 2'd1);
        if (a == 23) chk("s2_idle_23", stage_mode[5:4], 2'd3);
        if (a == 24) chk("s2_fill_24", stage_mode[5:4], 2'd0);
        if (a == 28) chk("s2_bfly_28", stage_mode[5:4], 2'd1);
        if (a == 31) chk("first_idx_31", out_index, 5'd0);
        if (a == 32) chk("idx_32", out_index, 5'd16);
        if (a == 33) chk("idx_33", out_index, 5'd8);
        if (a == 34) chk("idx_34", out_index, 5'd24);
        if (a == 33) chk("s0_tw_33", {stage_mode[1:0], tw_idx[3:0]}, {2'd2, 4'd1});
        if (a == 38) chk("s1_tw_38", {stage_mode[3:2], tw_idx[7:4]}, {2'd2, 4'd12});
        if (a == 47) chk("s0_tw_47", {stage_mode[1:0], tw_idx[3:0]}, {2'd2, 4'd15});
    endtask

    // nf frames, optional stall before sample stall_at, optional in_valid held high in FLUSH,
    // optional reset at flush cycle abort_at.
    task automatic run_frames(input int nf, input int stall_at, input int stall_len,
                              input logic flush_valid, input int abort_at);
        logic [29:0] e;
        for (int a = 0; a < 32 * nf; a++) begin
            if (a == stall_at) begin
                e = exp_dec(a);
                for (int s = 0; s < stall_len; s++) begin
                    drive(1'b0);
                    chk($sformatf("stall_adv%0d", s), advance, 0);
                    chk($sformatf("stall_rdy%0d", s), in_ready, 1);
                    chk($sformatf("stall_busy%0d", s), busy, 1);
                    chk($sformatf("stall_oval%0d", s), out_valid, 0);
                    chk($sformatf("stall_mode%0d", s), stage_mode, e[9:0]);
                    chk($sformatf("stall_tw%0d", s), tw_idx, e[29:10]);
                end
            end
            drive(1'b1);
            chk($sformatf("in_ready@%0d", a), in_ready, 1);
            if (a > 0) chk($sformatf("busy@%0d", a), busy, 1);
            check_adv(a);
        end
        drive(1'b0);
        e = exp_dec(32 * nf);
        chk("bnd_advance", advance, 0);
        chk("bnd_out_valid", out_valid, 0);
        chk("bnd_out_index", out_index, 0);
        chk("bnd_in_ready", in_ready, 1);
        chk("bnd_state", dbg_state, 2'd1);
        chk("bnd_mode", stage_mode, e[9:0]);
        for (int f = 0; f < 31; f++) begin
            drive(flush_valid);
            if (f == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                check_reset_outputs("rst_mid_flush");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            chk($sformatf("fl_in_ready@%0d", f), in_ready, 0);
            chk($sformatf("fl_busy@%0d", f), busy, 1);
            chk($sformatf("fl_state@%0d", f), dbg_state, 2'd2);
            check_adv(32 * nf + f);
        end
        if (!flush_valid) begin
            drive(1'b0);
            check_reset_outputs("idle_after");
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        run_frames(1, -1, 0, 1'b0, -1);
        run_frames(2, -1, 0, 1'b0, -1);
        run_frames(1, 10, 5, 1'b0, -1);
        run_frames(1, -1, 0, 1'b1, -1);
        run_frames(1, -1, 0, 1'b0, -1);
        run_frames(1, -1, 0, 1'b0, 10);
        run_frames(1, -1, 0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
